// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: the MEM->WB bus layout,
// CP0 register addresses, CP0 write masks and exception constants.
package wb_stage_pkg;

  localparam int BUS_W = 118;

  // Bit offsets of the MEM->WB bus fields (LSB of each field)
  localparam int OFS_RF_WEN     = 117;
  localparam int OFS_RF_WDEST   = 112;
  localparam int OFS_MEM_RESULT = 80;
  localparam int OFS_LO_RESULT  = 48;
  localparam int OFS_HI_WRITE   = 47;
  localparam int OFS_LO_WRITE   = 46;
  localparam int OFS_MFHI       = 45;
  localparam int OFS_MFLO       = 44;
  localparam int OFS_MTC0       = 43;
  localparam int OFS_MFC0       = 42;
  localparam int OFS_CP0R_ADDR  = 34;
  localparam int OFS_SYSCALL    = 33;
  localparam int OFS_ERET       = 32;
  localparam int OFS_PC         = 0;

  // Field order mirrors the bus, MSB first
  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic [31:0] pc;
  } mem_wb_bus_t;

  // CP0 addresses are {rd[4:0], sel[2:0]}
  localparam logic [7:0] CP0_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC    = {5'd14, 3'd0};

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000;
  localparam logic [4:0]  EXC_SYS        = 5'd8;

endpackage

// File: rtl/wb_stage_if.sv
// Write-back stage bus interface.
// Inputs to the stage : WB_valid, MEM_WB_bus_r
// Outputs of the stage: register-file write port, WB_over/WB_wdest,
//                       exception redirect, and display values.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic             WB_valid;
  logic [BUS_W-1:0] MEM_WB_bus_r;

  logic             rf_wen;
  logic [4:0]       rf_wdest;
  logic [31:0]      rf_wdata;
  logic             WB_over;
  logic [4:0]       WB_wdest;
  logic             exc_valid;
  logic [31:0]      exc_pc;
  logic             cancel;
  logic [31:0]      WB_pc;
  logic [31:0]      HI_data;
  logic [31:0]      LO_data;
  logic [31:0]      cp0r_status;
  logic [31:0]      cp0r_cause;
  logic [31:0]      cp0r_epc;

  modport master (
    output WB_valid, MEM_WB_bus_r,
    input  rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, exc_valid, exc_pc,
           cancel, WB_pc, HI_data, LO_data, cp0r_status, cp0r_cause, cp0r_epc
  );

  modport slave (
    input  WB_valid, MEM_WB_bus_r,
    output rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, exc_valid, exc_pc,
           cancel, WB_pc, HI_data, LO_data, cp0r_status, cp0r_cause, cp0r_epc
  );
endinterface

// File: rtl/wb_stage_cp0_regs.sv
// CP0 register file (STATUS, CAUSE, EPC) for the write-back stage.
// Ports: clk/reset; valid_i qualifies mtc0_i/syscall_i/eret_i;
// addr_i selects the register for mtc0 writes and for rdata_o;
// wdata_i is the mtc0 data; pc_i is the syscall PC saved into EPC;
// status_o/cause_o/epc_o expose the current register values.
module cp0_regs
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        mtc0_i,
  input  logic        syscall_i,
  input  logic        eret_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] pc_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q,  cause_d;
  logic [31:0] epc_q,    epc_d;

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (valid_i) begin
      if (mtc0_i) begin
        case (addr_i)
          CP0_STATUS: status_d = wdata_i & STATUS_WMASK;
          // ExcCode bits are not software-writable and must survive the write
          CP0_CAUSE:  cause_d  = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
          CP0_EPC:    epc_d    = wdata_i;
          default:    ;
        endcase
      end
      // Exception updates win over a same-instruction mtc0
      if (syscall_i) begin
        status_d[1]   = 1'b1;
        cause_d[6:2]  = EXC_SYS;
        epc_d         = pc_i;
      end
      if (eret_i) begin
        status_d[1] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= 32'h0;
      cause_q  <= 32'h0;
      epc_q    <= 32'h0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    case (addr_i)
      CP0_STATUS: rdata_o = status_q;
      CP0_CAUSE:  rdata_o = cause_q;
      CP0_EPC:    rdata_o = epc_q;
      default:    rdata_o = 32'h0;
    endcase
  end

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: drives the register-file write port, owns HI/LO,
// hosts the CP0 registers and raises syscall/eret redirects.
// Ports: clk, reset (sync, active-high); wb (wb_stage_if.slave) carries
// WB_valid and the MEM->WB bus in, and all stage outputs out.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  wb_stage_if.slave    wb
);

  mem_wb_bus_t bus;
  assign bus = mem_wb_bus_t'(wb.MEM_WB_bus_r);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] cp0_rdata;
  logic [31:0] epc;
  logic        exc;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb.WB_valid && bus.hi_write) hi_d = bus.mem_result;
    if (wb.WB_valid && bus.lo_write) lo_d = bus.lo_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  cp0_regs u_cp0 (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (wb.WB_valid),
    .mtc0_i    (bus.mtc0),
    .syscall_i (bus.syscall),
    .eret_i    (bus.eret),
    .addr_i    (bus.cp0r_addr),
    .wdata_i   (bus.mem_result),
    .pc_i      (bus.pc),
    .rdata_o   (cp0_rdata),
    .status_o  (wb.cp0r_status),
    .cause_o   (wb.cp0r_cause),
    .epc_o     (epc)
  );

  assign exc = wb.WB_valid & (bus.syscall | bus.eret);

  // mfhi/mflo read the pre-edge register value, so select from *_q
  always_comb begin
    if (bus.mfhi)      wb.rf_wdata = hi_q;
    else if (bus.mflo) wb.rf_wdata = lo_q;
    else if (bus.mfc0) wb.rf_wdata = cp0_rdata;
    else               wb.rf_wdata = bus.mem_result;
  end

  assign wb.rf_wen      = bus.rf_wen & wb.WB_valid & ~(bus.syscall | bus.eret);
  assign wb.rf_wdest    = bus.rf_wdest;
  assign wb.WB_over     = wb.WB_valid;
  assign wb.WB_wdest    = wb.WB_valid ? bus.rf_wdest : 5'd0;
  assign wb.exc_valid   = exc;
  assign wb.cancel      = exc;
  assign wb.exc_pc      = bus.syscall ? EXC_ENTER_ADDR : epc;
  assign wb.WB_pc       = bus.pc;
  assign wb.HI_data     = hi_q;
  assign wb.LO_data     = lo_q;
  assign wb.cp0r_epc    = epc;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_stage_if bus_if ();

  wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Current instruction fields
  logic        c_valid, c_reset;
  logic        c_rfw, c_hw, c_lw, c_mfhi, c_mflo, c_mtc0, c_mfc0, c_sys, c_eret;
  logic [4:0]  c_wd;
  logic [31:0] c_mem, c_lo, c_pc;
  logic [7:0]  c_addr;

  // Architectural reference state
  logic [31:0] m_hi, m_lo, m_status, m_cause, m_epc;

  localparam logic [7:0] A_STATUS = 8'h60;
  localparam logic [7:0] A_CAUSE  = 8'h68;
  localparam logic [7:0] A_EPC    = 8'h70;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_fields();
    c_valid = 1'b1; c_reset = 1'b0;
    c_rfw = 0; c_hw = 0; c_lw = 0; c_mfhi = 0; c_mflo = 0;
    c_mtc0 = 0; c_mfc0 = 0; c_sys = 0; c_eret = 0;
    c_wd = 5'd0; c_mem = 32'h0; c_lo = 32'h0; c_pc = 32'h0; c_addr = 8'h0;
  endtask

  function automatic logic [31:0] cp0_read(input logic [7:0] a);
    if (a == A_STATUS) return m_status;
    if (a == A_CAUSE)  return m_cause;
    if (a == A_EPC)    return m_epc;
    return 32'h0;
  endfunction

  // Drive current fields and compare combinational outputs on the falling edge
  task automatic drive(input bit do_check);
    reset = c_reset;
    bus_if.WB_valid = c_valid;
    bus_if.MEM_WB_bus_r = {c_rfw, c_wd, c_mem, c_lo, c_hw, c_lw, c_mfhi, c_mflo,
                           c_mtc0, c_mfc0, c_addr, c_sys, c_eret, c_pc};
    @(negedge clk);
    if (do_check) begin
      logic [31:0] wdata;
      logic        exc;
      wdata = c_mfhi ? m_hi : c_mflo ? m_lo : c_mfc0 ? cp0_read(c_addr) : c_mem;
      exc   = c_valid & (c_sys | c_eret);
      chk("rf_wen",   {31'd0, bus_if.rf_wen},   {31'd0, c_rfw & c_valid & ~(c_sys | c_eret)});
      chk("rf_wdest", {27'd0, bus_if.rf_wdest}, {27'd0, c_wd});
      chk("rf_wdata", bus_if.rf_wdata, wdata);
      chk("WB_over",  {31'd0, bus_if.WB_over},  {31'd0, c_valid});
      chk("WB_wdest", {27'd0, bus_if.WB_wdest}, {27'd0, c_valid ? c_wd : 5'd0});
      chk("exc_valid",{31'd0, bus_if.exc_valid},{31'd0, exc});
      chk("cancel",   {31'd0, bus_if.cancel},   {31'd0, exc});
      if (exc) chk("exc_pc", bus_if.exc_pc, c_sys ? 32'h0 : m_epc);
      chk("WB_pc",    bus_if.WB_pc, c_pc);
      chk("HI_data",  bus_if.HI_data, m_hi);
      chk("LO_data",  bus_if.LO_data, m_lo);
      chk("status",   bus_if.cp0r_status, m_status);
      chk("cause",    bus_if.cp0r_cause, m_cause);
      chk("epc",      bus_if.cp0r_epc, m_epc);
    end
  endtask

  // Rising edge: advance the reference state by the instruction's effects
  task automatic tick();
    @(posedge clk);
    if (c_reset) begin
      m_hi = 0; m_lo = 0; m_status = 0; m_cause = 0; m_epc = 0;
    end else if (c_valid) begin
      if (c_hw) m_hi = c_mem;
      if (c_lw) m_lo = c_lo;
      if (c_mtc0) begin
        if (c_addr == A_STATUS) m_status = c_mem & 32'h0000_FF03;
        else if (c_addr == A_CAUSE) m_cause = (m_cause & ~32'h0000_0300) | (c_mem & 32'h0000_0300);
        else if (c_addr == A_EPC) m_epc = c_mem;
      end
      if (c_sys) begin
        m_status = m_status | 32'h2;
        m_cause  = (m_cause & ~32'h0000_007C) | (32'd8 << 2);
        m_epc    = c_pc;
      end
      if (c_eret) m_status = m_status & ~32'h2;
    end
    #1;
  endtask

  task automatic step(input bit do_check);
    drive(do_check);
    tick();
  endtask

  initial begin
    m_hi = 'x; m_lo = 'x; m_status = 'x; m_cause = 'x; m_epc = 'x;

    // Reset with an in-flight syscall: state must still clear
    clear_fields();
    c_reset = 1; c_sys = 1; c_pc = 32'h0000_0080; c_rfw = 1;
    step(0);
    drive(1);
    chk("rst_exc_valid", {31'd0, bus_if.exc_valid}, 32'd1);
    tick();
    chk("rst_epc", bus_if.cp0r_epc, 32'h0);
    chk("rst_status", bus_if.cp0r_status, 32'h0);
    chk("rst_hi", bus_if.HI_data, 32'h0);

    // ADD
    clear_fields();
    c_rfw = 1; c_wd = 5'd5; c_mem = 32'h1234;
    drive(1);
    chk("add_wdata", bus_if.rf_wdata, 32'h1234);
    chk("add_wen", {31'd0, bus_if.rf_wen}, 32'd1);
    tick();

    // mult then mfhi / mflo
    clear_fields();
    c_hw = 1; c_lw = 1; c_mem = 32'hAAAA_0001; c_lo = 32'h5555_0002;
    step(1);
    clear_fields(); c_rfw = 1; c_wd = 5'd7; c_mfhi = 1; c_mem = 32'hDEAD_BEEF;
    drive(1); chk("mfhi", bus_if.rf_wdata, 32'hAAAA_0001); tick();
    clear_fields(); c_rfw = 1; c_wd = 5'd8; c_mflo = 1;
    drive(1); chk("mflo", bus_if.rf_wdata, 32'h5555_0002); tick();

    // mfhi in the same cycle as a HI write sees the old value
    clear_fields(); c_rfw = 1; c_mfhi = 1; c_hw = 1; c_mem = 32'h0BAD_F00D;
    drive(1); chk("mfhi_old", bus_if.rf_wdata, 32'hAAAA_0001); tick();

    // syscall
    clear_fields(); c_sys = 1; c_rfw = 1; c_pc = 32'h0000_0040;
    drive(1);
    chk("sys_exc_pc", bus_if.exc_pc, 32'h0);
    chk("sys_rf_wen", {31'd0, bus_if.rf_wen}, 32'd0);
    tick();
    chk("sys_epc", bus_if.cp0r_epc, 32'h40);
    chk("sys_code", {27'd0, bus_if.cp0r_cause[6:2]}, 32'd8);
    chk("sys_exl", {31'd0, bus_if.cp0r_status[1]}, 32'd1);

    // mtc0 EPC then eret
    clear_fields(); c_mtc0 = 1; c_addr = A_EPC; c_mem = 32'h0000_0044;
    step(1);
    clear_fields(); c_eret = 1;
    drive(1); chk("eret_pc", bus_if.exc_pc, 32'h44); tick();
    chk("eret_exl", {31'd0, bus_if.cp0r_status[1]}, 32'd0);

    // mtc0 STATUS all-ones, mfc0 reads masked value
    clear_fields(); c_mtc0 = 1; c_addr = A_STATUS; c_mem = 32'hFFFF_FFFF;
    step(1);
    clear_fields(); c_mfc0 = 1; c_addr = A_STATUS; c_rfw = 1;
    drive(1); chk("mfc0_status", bus_if.rf_wdata, 32'h0000_FF03); tick();

    // mtc0 with WB_valid low changes nothing
    clear_fields(); c_valid = 0; c_mtc0 = 1; c_addr = A_STATUS; c_mem = 32'h0;
    c_hw = 1; c_rfw = 1;
    step(1);
    chk("novalid_status", bus_if.cp0r_status, 32'h0000_FF03);

    // CAUSE masking and unmapped address
    clear_fields(); c_mtc0 = 1; c_addr = A_CAUSE; c_mem = 32'hFFFF_FFFF;
    step(1);
    chk("cause_mask", bus_if.cp0r_cause, 32'h0000_0320);
    clear_fields(); c_mtc0 = 1; c_addr = 8'h08; c_mem = 32'h1111_1111;
    step(1);
    clear_fields(); c_mfc0 = 1; c_addr = 8'h08;
    drive(1); chk("mfc0_unmapped", bus_if.rf_wdata, 32'h0); tick();

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      int kind;
      clear_fields();
      kind    = $urandom_range(0, 5);
      c_valid = ($urandom_range(0, 7) != 0);
      c_reset = ($urandom_range(0, 59) == 0);
      c_rfw   = $urandom_range(0, 1);
      c_wd    = 5'($urandom);
      c_mem   = $urandom;
      c_lo    = $urandom;
      c_pc    = $urandom;
      case ($urandom_range(0, 3))
        0: c_addr = A_STATUS;
        1: c_addr = A_CAUSE;
        2: c_addr = A_EPC;
        default: c_addr = 8'($urandom);
      endcase
      case (kind)
        1: c_mtc0 = 1;
        2: c_sys = 1;
        3: c_eret = 1;
        4: c_mfc0 = 1;
        5: begin c_hw = $urandom_range(0, 1); c_lw = $urandom_range(0, 1); end
        default: begin c_mfhi = $urandom_range(0, 1); c_mflo = $urandom_range(0, 1); end
      endcase
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  one clock; reset is synchronous and active-high.
REQ-003 WB_valid  input  1  WB holds a valid instruction.
REQ-004 MEM_WB_bus_r  input  118  registered MEM->WB bus, fields MSB->LSB: rf_wen[117], rf_wdest[116:112], mem_result[111:80], lo_result[79:48], hi_write[47], lo_write[46], mfhi[45], mflo[44], mtc0[43], mfc0[42], cp0r_addr[41:34] ({rd,sel}), syscall[33], eret[32], pc[31:0].
REQ-005 rf_wen  output  1  register-file write enable.
REQ-006 rf_wdest  output  5  register-file write address.
REQ-007 rf_wdata  output  32  register-file write data.
REQ-008 WB_over  output  1  WB completes this cycle.
REQ-009 WB_wdest  output  5  destination for hazard detection, zero when WB_valid=0.
REQ-010 exc_valid  output  1  redirect request (syscall or eret) this cycle.
REQ-011 exc_pc  output  32  redirect target.
REQ-012 cancel  output  1  flush of all younger stages, equals exc_valid.
REQ-013 WB_pc, HI_data, LO_data, cp0r_status, cp0r_cause, cp0r_epc  output  32 each  display values.

Function
REQ-014 WB_over SHALL equal WB_valid (single-cycle stage, no stall).
REQ-015 rf_wen SHALL be bus rf_wen AND WB_valid AND NOT(syscall OR eret); rf_wdest SHALL be bus rf_wdest.
REQ-016 rf_wdata SHALL select HI if mfhi, else LO if mflo, else CP0 read data if mfc0, else mem_result.
REQ-017 HI SHALL load mem_result at the edge when WB_valid AND hi_write; LO SHALL load lo_result when WB_valid AND lo_write; both independently, same edge allowed (mult).
REQ-018 mfhi/mflo SHALL read the register value before the current edge's update.
REQ-019 CP0 addresses: STATUS={12,0}, CAUSE={13,0}, EPC={14,0}; any other cp0r_addr reads 0 and ignores writes.
REQ-020 mtc0 (WB_valid) SHALL write mem_result: STATUS bits [15:8],[1],[0] writable, others read 0; CAUSE only bits [9:8] writable; EPC all 32 bits.
REQ-021 syscall (WB_valid) SHALL at the edge set STATUS[1] (EXL)=1, CAUSE[6:2]=5'd8, EPC=pc; exc_valid=1, exc_pc=EXC_ENTER_ADDR (32'h0000_0000) combinationally in that cycle.
REQ-022 eret (WB_valid) SHALL clear STATUS[1] at the edge; exc_valid=1, exc_pc=current EPC register value in that cycle.
REQ-023 exc_valid SHALL be a one-cycle pulse per syscall/eret instruction; 0 when WB_valid=0.
REQ-024 With WB_valid=0, no HI/LO/CP0 state SHALL change and rf_wen SHALL be 0.
REQ-025 mtc0 EPC followed by eret next cycle SHALL redirect to the newly written EPC.
REQ-026 WB_pc SHALL be bus pc; display outputs SHALL show current register values.

Reset
REQ-027 reset SHALL dominate every other event in the same cycle, including an in-flight syscall/mtc0.
REQ-028 After reset HI, LO, STATUS, CAUSE, EPC SHALL be 32'h0; combinational outputs follow inputs (rf_wen, exc_valid, cancel still gated by WB_valid).

Structure
REQ-029 Shared package SHALL hold bus field offsets/width (118), CP0 addresses, write masks, EXC_ENTER_ADDR, ExcCode SYS=5'd8.
REQ-030 CP0 registers SHALL be a sub-module cp0_regs (read mux, masked writes, syscall/eret updates); HI/LO stay in wb_stage.

Verification
REQ-031 Reset with syscall on bus, WB_valid=1 -> all regs 0 after edge, EPC unchanged 0.
REQ-032 ADD bus rf_wen=1, wdest=5, mem_result=32'h1234 -> rf_wen=1, rf_wdest=5, rf_wdata=32'h1234, WB_over=1.
REQ-033 mult hi=32'hAAAA_0001, lo=32'h5555_0002, both writes, then mfhi/mflo -> rf_wdata 32'hAAAA_0001 then 32'h5555_0002.
REQ-034 syscall pc=32'h0000_0040 -> exc_valid=1, exc_pc=0, rf_wen=0; next cycle EPC=32'h40, CAUSE[6:2]=8, STATUS[1]=1.
REQ-035 mtc0 EPC=32'h0000_0044 then eret -> exc_pc=32'h44, STATUS[1]=0 after edge.
REQ-036 mtc0 STATUS=32'hFFFF_FFFF, then mfc0 -> rf_wdata=32'h0000_FF03; WB_valid=0 with mtc0 -> no change.
